pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as follows: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these parameter and configuration inputs:
- MEM_TIMEOUT, default 255, maximum number of MEM_WAIT cycles.
- fwd_en  in  1  forwarding enabled; only load-use hazards stall when set.
REQ-003 The block SHALL have these ID-stage inputs:
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  4 each  source register numbers.
- id_two_src  in  1  id_src2 is read.
REQ-004 The block SHALL have these EX-stage inputs:
- exe_wb_en  in  1  EX writes back.
- exe_mem_r_en  in  1  EX is a load.
- exe_dest  in  4  EX destination register.
- exe_branch_taken  in  1  EX resolves a taken branch.
REQ-005 The block SHALL have these MEM-stage inputs:
- mem_wb_en  in  1  MEM writes back.
- mem_dest  in  4  MEM destination register.
- mem_req  in  1  MEM stage performs a load or store.
- mem_ready  in  1  memory completion strobe.
REQ-006 The block SHALL have these outputs:
- mem_start  out  1  one-cycle memory launch pulse.
- freeze_all  out  1  holds PC and all four pipeline registers.
- freeze_front  out  1  holds PC and IF/ID.
- flush_if_id  out  1  clears the IF/ID register.
- flush_id_exe  out  1  clears the ID/EX register (bubble).
- mem_timeout_err  out  1  sticky error flag.
- hz_stall_cnt  out  16  count of hazard-stall cycles.
- mem_wait_cnt  out  16  count of memory-wait cycles.

Function
REQ-007 The FSM SHALL have three states: RUN, MEM_WAIT and RELEASE.
REQ-008 In RUN, when mem_req=1, the block SHALL assert mem_start combinationally in that cycle and SHALL enter MEM_WAIT on the next edge.
REQ-009 In MEM_WAIT, freeze_all SHALL be 1 and mem_start SHALL be 0.
REQ-010 In MEM_WAIT, mem_ready=1 SHALL cause a transition to RELEASE.
REQ-011 In RELEASE, freeze_all SHALL be 0 and mem_req SHALL be ignored for that cycle; the next state SHALL be RUN.
REQ-012 The MEM_WAIT cycle counter SHALL be 8 bits; on reaching MEM_TIMEOUT without mem_ready, the block SHALL set mem_timeout_err and go to RELEASE.
REQ-013 mem_ready received outside MEM_WAIT SHALL be ignored.
REQ-014 Data hazard with fwd_en=0: id_valid AND ((exe_wb_en AND exe_dest==src) OR (mem_wb_en AND mem_dest==src)), where src is id_src1, or id_src2 when id_two_src=1.
REQ-015 Data hazard with fwd_en=1: id_valid AND exe_mem_r_en AND exe_dest==src; MEM-stage matches SHALL be ignored.
REQ-016 Output priority SHALL be: freeze_all, then branch, then hazard.
REQ-017 While freeze_all=1, freeze_front, flush_if_id and flush_id_exe SHALL all be 0.
REQ-018 With no freeze and exe_branch_taken=1, flush_if_id and flush_id_exe SHALL be 1, freeze_front SHALL be 0, and any hazard SHALL be ignored.
REQ-019 With no freeze and no branch, a hazard SHALL assert freeze_front=1 and flush_id_exe=1.
REQ-020 A branch in EX held during a memory freeze SHALL be flushed in the RELEASE cycle.
REQ-021 hz_stall_cnt SHALL increment by 1 per cycle with freeze_front=1.
REQ-022 mem_wait_cnt SHALL increment by 1 per cycle in MEM_WAIT.
REQ-023 Both 16-bit counters SHALL saturate at 0xFFFF.
REQ-024 All flag outputs SHALL be decoded combinationally from the registered state and the current inputs; the counters SHALL be registered.

Reset
REQ-025 rst=0 sampled at a clk edge SHALL force the following, overriding any in-progress MEM_WAIT:
- state to RUN.
- wait counter to 0.
- mem_timeout_err, hz_stall_cnt and mem_wait_cnt to 0.
REQ-026 While rst=0, mem_start, freeze_all, freeze_front, flush_if_id and flush_id_exe SHALL be 0.
REQ-027 mem_timeout_err SHALL be cleared only by reset.

Structure
REQ-028 The state encoding (2-bit: RUN, MEM_WAIT, RELEASE) and the default of MEM_TIMEOUT SHALL live in the shared pipeline package.
REQ-029 The hazard comparison SHALL be one combinational sub-module, hazard_detect, and the FSM and counters SHALL be in pipe_hazard_ctrl.

Verification
REQ-030 fwd_en=0, id_src1=3, exe_wb_en=1, exe_dest=3 -> freeze_front=1, flush_id_exe=1, hz_stall_cnt +1.
REQ-031 fwd_en=1, id_src2=5, id_two_src=1, exe_mem_r_en=1, exe_dest=5 -> one stall cycle; with id_two_src=0 -> no stall.
REQ-032 mem_req=1, mem_ready after 4 cycles -> mem_start for 1 cycle, freeze_all for 4 cycles, RELEASE, mem_wait_cnt=4.
REQ-033 exe_branch_taken=1 together with a hazard -> flush_if_id=1, flush_id_exe=1, freeze_front=0.
REQ-034 MEM_TIMEOUT=8, mem_ready never asserted -> mem_timeout_err=1 after 8 wait cycles, sticky until rst=0.
REQ-035 rst=0 mid-MEM_WAIT -> next cycle state RUN, all outputs 0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding, memory timeout
// default and the saturating counter helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RELEASE  = 2'd2
  } state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W              = 8;
  localparam int CNT_W               = 16;
  localparam int REG_W               = 4;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard check between the ID-stage sources and the EX/MEM
// destinations, with or without operand forwarding.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);

  logic exe_match;
  logic mem_match;

  assign exe_match = (exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2));
  assign mem_match = (mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2));

  // With forwarding only a load in EX cannot supply its result in time.
  assign hazard = id_valid && (fwd_en ? (exe_mem_r_en && exe_match)
                                      : ((exe_wb_en && exe_match) || (mem_wb_en && mem_match)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, branch flush / data-hazard stall
// decode, and saturating stall statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_start,
  output logic             freeze_all,
  output logic             freeze_front,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] hz_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  // wait_cnt counts completed wait cycles, so MEM_WAIT lasts at most MEM_TIMEOUT cycles.
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                timeout_hit;
  logic                hazard;

  hazard_detect u_hazard_detect (
    .fwd_en       (fwd_en),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
    mem_start    = 1'b0;
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;

    unique case (state)
      ST_RUN: begin
        wait_cnt_nxt = '0;
        if (mem_req) begin
          mem_start = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        freeze_all = 1'b1;
        if (mem_ready) begin
          state_nxt = ST_RELEASE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RELEASE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_RELEASE: state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase

    // Branch beats hazard; a branch held during a freeze flushes once the freeze drops.
    if (!freeze_all) begin
      if (exe_branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (hazard) begin
        freeze_front = 1'b1;
        flush_id_exe = 1'b1;
      end
    end

    if (!rst) begin
      mem_start    = 1'b0;
      freeze_all   = 1'b0;
      freeze_front = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_exe = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst) begin
      state           <= ST_RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      hz_stall_cnt    <= '0;
      mem_wait_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit)          mem_timeout_err <= 1'b1;
      if (freeze_front)         hz_stall_cnt    <= sat_inc(hz_stall_cnt);
      if (state == ST_MEM_WAIT) mem_wait_cnt    <= sat_inc(mem_wait_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, branch priority, memory wait,
// timeout and reset behaviour with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        fwd_en, id_valid, id_two_src;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        exe_wb_en, exe_mem_r_en, exe_branch_taken;
  logic        mem_wb_en, mem_req, mem_ready;
  logic        mem_start, freeze_all, freeze_front, flush_if_id, flush_id_exe;
  logic        mem_timeout_err;
  logic [15:0] hz_stall_cnt, mem_wait_cnt;
  logic [4:0]  flags;

  int n_pass  = 0;
  int n_total = 0;
  int exp_hz  = 0;
  int exp_mw  = 0;

  // {mem_start, freeze_all, freeze_front, flush_if_id, flush_id_exe}
  assign flags = {mem_start, freeze_all, freeze_front, flush_if_id, flush_id_exe};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .fwd_en           (fwd_en),
    .id_valid         (id_valid),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_two_src       (id_two_src),
    .exe_wb_en        (exe_wb_en),
    .exe_mem_r_en     (exe_mem_r_en),
    .exe_dest         (exe_dest),
    .exe_branch_taken (exe_branch_taken),
    .mem_wb_en        (mem_wb_en),
    .mem_dest         (mem_dest),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .mem_start        (mem_start),
    .freeze_all       (freeze_all),
    .freeze_front     (freeze_front),
    .flush_if_id      (flush_if_id),
    .flush_id_exe     (flush_id_exe),
    .mem_timeout_err  (mem_timeout_err),
    .hz_stall_cnt     (hz_stall_cnt),
    .mem_wait_cnt     (mem_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    fwd_en = 0; id_valid = 0; id_two_src = 0; id_src1 = 0; id_src2 = 0;
    exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0; exe_branch_taken = 0;
    mem_wb_en = 0; mem_dest = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    clear_inputs();
    mem_req = 1; exe_branch_taken = 1; id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_dest = 3;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL reset_flags: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    n_total++;
    if (hz_stall_cnt !== 16'd0 || mem_wait_cnt !== 16'd0 || mem_timeout_err !== 1'b0)
      $display("FAIL reset_counters: got hz=%0d mw=%0d err=%b want 0 0 0", hz_stall_cnt, mem_wait_cnt, mem_timeout_err);
    else n_pass++;
    rst = 1;
    clear_inputs();
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL reset_idle_flags: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
  endtask

  task automatic test_hazard_nofwd;
    clear_inputs();
    id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_dest = 3;
    // Three back-to-back stall cycles on an EX match.
    for (int i = 0; i < 3; i++) begin
      #2;
      n_total++;
      if (flags !== 5'b00101) $display("FAIL nofwd_exe_flags[%0d]: got %b want %b", i, flags, 5'b00101); else n_pass++;
      tick();
      exp_hz++;
      n_total++;
      if (hz_stall_cnt !== 16'(exp_hz)) $display("FAIL nofwd_exe_cnt[%0d]: got %0d want %0d", i, hz_stall_cnt, exp_hz); else n_pass++;
    end
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 3;
    #2;
    n_total++;
    if (flags !== 5'b00101) $display("FAIL nofwd_mem_flags: got %b want %b", flags, 5'b00101); else n_pass++;
    tick();
    exp_hz++;
    id_src1 = 1; id_src2 = 3; id_two_src = 0;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL nofwd_src2_unused: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    id_two_src = 1; id_valid = 0;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL nofwd_id_invalid: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    n_total++;
    if (hz_stall_cnt !== 16'(exp_hz)) $display("FAIL nofwd_cnt_hold: got %0d want %0d", hz_stall_cnt, exp_hz); else n_pass++;
  endtask

  task automatic test_hazard_fwd;
    clear_inputs();
    fwd_en = 1; id_valid = 1; id_src1 = 0; id_src2 = 5; id_two_src = 1; exe_mem_r_en = 1; exe_dest = 5;
    #2;
    n_total++;
    if (flags !== 5'b00101) $display("FAIL fwd_load_use: got %b want %b", flags, 5'b00101); else n_pass++;
    tick();
    exp_hz++;
    n_total++;
    if (hz_stall_cnt !== 16'(exp_hz)) $display("FAIL fwd_load_use_cnt: got %0d want %0d", hz_stall_cnt, exp_hz); else n_pass++;
    id_two_src = 0;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL fwd_src2_unused: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    id_two_src = 1; exe_mem_r_en = 0; exe_wb_en = 1; mem_wb_en = 1; mem_dest = 5;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL fwd_non_load: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    n_total++;
    if (hz_stall_cnt !== 16'(exp_hz)) $display("FAIL fwd_cnt_hold: got %0d want %0d", hz_stall_cnt, exp_hz); else n_pass++;
  endtask

  task automatic test_branch_priority;
    clear_inputs();
    id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_dest = 3; exe_branch_taken = 1;
    #2;
    n_total++;
    if (flags !== 5'b00011) $display("FAIL branch_over_hazard: got %b want %b", flags, 5'b00011); else n_pass++;
    tick();
    n_total++;
    if (hz_stall_cnt !== 16'(exp_hz)) $display("FAIL branch_cnt_hold: got %0d want %0d", hz_stall_cnt, exp_hz); else n_pass++;
  endtask

  task automatic test_mem_wait;
    clear_inputs();
    mem_ready = 1;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL stray_ready: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    mem_ready = 0; mem_req = 1;
    #2;
    n_total++;
    if (flags !== 5'b10000) $display("FAIL mem_start: got %b want %b", flags, 5'b10000); else n_pass++;
    tick();
    // Branch and hazard held during the freeze must stay masked.
    mem_req = 0; exe_branch_taken = 1; id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_dest = 3;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #2;
      n_total++;
      if (flags !== 5'b01000) $display("FAIL mem_wait_flags[%0d]: got %b want %b", i, flags, 5'b01000); else n_pass++;
      tick();
      exp_mw++;
    end
    mem_ready = 0; mem_req = 1;
    #2;
    n_total++;
    if (flags !== 5'b00011) $display("FAIL release_flags: got %b want %b", flags, 5'b00011); else n_pass++;
    n_total++;
    if (mem_wait_cnt !== 16'(exp_mw)) $display("FAIL mem_wait_cnt: got %0d want %0d", mem_wait_cnt, exp_mw); else n_pass++;
    tick();
    clear_inputs();
    #2;
    n_total++;
    if (flags !== 5'b00000 || mem_timeout_err !== 1'b0)
      $display("FAIL back_to_run: got flags=%b err=%b want 00000 0", flags, mem_timeout_err);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout;
    clear_inputs();
    mem_req = 1;
    tick();
    mem_req = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      n_total++;
      if (flags !== 5'b01000 || mem_timeout_err !== 1'b0)
        $display("FAIL timeout_wait[%0d]: got flags=%b err=%b want 01000 0", i, flags, mem_timeout_err);
      else n_pass++;
      tick();
      exp_mw++;
    end
    #2;
    n_total++;
    if (flags !== 5'b00000 || mem_timeout_err !== 1'b1)
      $display("FAIL timeout_release: got flags=%b err=%b want 00000 1", flags, mem_timeout_err);
    else n_pass++;
    n_total++;
    if (mem_wait_cnt !== 16'(exp_mw)) $display("FAIL timeout_mw_cnt: got %0d want %0d", mem_wait_cnt, exp_mw); else n_pass++;
    tick();
    mem_req = 1;
    tick();
    mem_req = 0; mem_ready = 1;
    tick();
    exp_mw++;
    mem_ready = 0;
    tick();
    #2;
    n_total++;
    if (mem_timeout_err !== 1'b1 || mem_wait_cnt !== 16'(exp_mw))
      $display("FAIL timeout_sticky: got err=%b mw=%0d want 1 %0d", mem_timeout_err, mem_wait_cnt, exp_mw);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    clear_inputs();
    mem_req = 1;
    tick();
    mem_req = 0;
    tick();
    rst = 0; exe_branch_taken = 1;
    #2;
    n_total++;
    if (flags !== 5'b00000) $display("FAIL reset_mid_wait_flags: got %b want %b", flags, 5'b00000); else n_pass++;
    tick();
    rst = 1; exe_branch_taken = 0;
    exp_hz = 0; exp_mw = 0;
    #2;
    n_total++;
    if (flags !== 5'b00000 || hz_stall_cnt !== 16'(exp_hz) || mem_wait_cnt !== 16'(exp_mw) || mem_timeout_err !== 1'b0)
      $display("FAIL reset_mid_wait_state: got flags=%b hz=%0d mw=%0d err=%b want 00000 0 0 0",
               flags, hz_stall_cnt, mem_wait_cnt, mem_timeout_err);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (freeze_all !== 1'b0) $display("FAIL reset_mid_wait_run: got freeze_all=%b want 0", freeze_all); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hazard_nofwd();
    test_hazard_fwd();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
